// File: rtl/input_conditioner_if.sv
// Pushbutton conditioner bus: raw levels and read strobe in, debounced levels,
// press pulses, sticky press flags and per-channel FSM state (2 bits/channel) out.
interface input_conditioner_if;
  // rd_ack is a single-cycle consume strobe with no backpressure: every cycle it
  // is 1 the consumer has taken the current press_flags, and they clear on that edge.
  logic [3:0] raw_buttons;
  logic       rd_ack;
  logic [3:0] pushbuttons;
  logic [3:0] press_evt;
  logic [3:0] press_flags;
  logic [7:0] state_dbg;

  modport master (
    output raw_buttons, rd_ack,
    input  pushbuttons, press_evt, press_flags, state_dbg
  );

  modport slave (
    input  raw_buttons, rd_ack,
    output pushbuttons, press_evt, press_flags, state_dbg
  );
endinterface

// File: rtl/input_conditioner.sv
// Four-channel pushbutton synchronizer + debouncer with press pulses.
// Optional sticky press flags are built only when PRESS_LATCH_EN is defined.
module input_conditioner #(
  parameter int DB_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input_conditioner_if.slave   bus
);

  localparam int NCH = 4;
  localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_e;

  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] pb_q;
  logic [NCH-1:0] evt_q;
  state_e         state_q [NCH];
  logic [7:0]     cnt_q   [NCH];

  // pb_q tracks "state is HELD or RELEASING", updated together with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      pb_q  <= '0;
      evt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q  <= bus.raw_buttons;
      s2_q  <= s1_q;
      evt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        case (state_q[i])
          IDLE: begin
            if (s2_q[i]) begin
              state_q[i] <= ARMING;
              cnt_q[i]   <= 8'd1;
            end
          end
          ARMING: begin
            if (!s2_q[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= HELD;
              cnt_q[i]   <= '0;
              pb_q[i]    <= 1'b1;
              evt_q[i]   <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + 8'd1;
            end
          end
          HELD: begin
            if (!s2_q[i]) begin
              state_q[i] <= RELEASING;
              cnt_q[i]   <= 8'd1;
            end
          end
          RELEASING: begin
            if (s2_q[i]) begin
              state_q[i] <= HELD;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
              pb_q[i]    <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 8'd1;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            pb_q[i]    <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.state_dbg = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.state_dbg[2*i +: 2] = state_q[i];
    end
  end

  assign bus.pushbuttons = pb_q;
  assign bus.press_evt   = evt_q;

`ifdef PRESS_LATCH_EN
  logic [NCH-1:0] flags_q;
  logic [NCH-1:0] flags_d;

  // A new press landing on the acknowledge edge must not be lost, so set wins.
  always_comb flags_d = (flags_q & ~{NCH{bus.rd_ack}}) | evt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign bus.press_flags = flags_q;
`else
  logic unused_rd_ack;
  assign unused_rd_ack   = bus.rd_ack;
  assign bus.press_flags = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DB_CYCLES=4; press_flags expectations
// follow whether PRESS_LATCH_EN is defined for the build.
module tb_input_conditioner;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  input_conditioner_if bus ();

  input_conditioner #(.DB_CYCLES(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.raw_buttons = 4'b1111;
    bus.rd_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (bus.pushbuttons !== 4'b0000 || bus.press_evt !== 4'b0000 ||
          bus.press_flags !== 4'b0000 || bus.state_dbg !== 8'h00)
        $display("FAIL reset_hold: pb=%b evt=%b flags=%b st=%h required all 0",
                 bus.pushbuttons, bus.press_evt, bus.press_flags, bus.state_dbg);
      else pass_cnt++;
    end
    bus.raw_buttons = 4'b0000;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    total_cnt++;
    if (bus.pushbuttons !== 4'b0000 || bus.state_dbg !== 8'h00)
      $display("FAIL reset_idle: pb=%b st=%h required 0000/00",
               bus.pushbuttons, bus.state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_pb;
    logic [3:0] exp_evt;
    logic [3:0] exp_fl;
    bus.raw_buttons = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_pb  = (k >= 5) ? 4'b0001 : 4'b0000;
      exp_evt = (k == 5) ? 4'b0001 : 4'b0000;
      total_cnt++;
      if (bus.pushbuttons !== exp_pb || bus.press_evt !== exp_evt)
        $display("FAIL clean_press_E%0d: pb=%b evt=%b required pb=%b evt=%b",
                 k, bus.pushbuttons, bus.press_evt, exp_pb, exp_evt);
      else pass_cnt++;
    end
`ifdef PRESS_LATCH_EN
    exp_fl = 4'b0001;
`else
    exp_fl = 4'b0000;
`endif
    total_cnt++;
    if (bus.press_flags !== exp_fl)
      $display("FAIL clean_press_flag: flags=%b required %b", bus.press_flags, exp_fl);
    else pass_cnt++;
    bus.raw_buttons = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      total_cnt++;
      if (bus.press_evt !== 4'b0000)
        $display("FAIL release_no_evt: evt=%b required 0000", bus.press_evt);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.pushbuttons !== 4'b0000 || bus.press_flags !== exp_fl)
      $display("FAIL release_done: pb=%b flags=%b required 0000/%b",
               bus.pushbuttons, bus.press_flags, exp_fl);
    else pass_cnt++;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    total_cnt++;
    if (bus.press_flags !== 4'b0000)
      $display("FAIL ack_clear: flags=%b required 0000", bus.press_flags);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b1110;
    for (int k = 0; k < 40; k++) begin
      bus.raw_buttons = {1'b0, pat[3 - (k % 4)], 2'b00};
      tick();
      total_cnt++;
      if (bus.pushbuttons !== 4'b0000 || bus.press_evt !== 4'b0000 ||
          bus.press_flags !== 4'b0000)
        $display("FAIL bounce_%0d: pb=%b evt=%b flags=%b required 0000",
                 k, bus.pushbuttons, bus.press_evt, bus.press_flags);
      else pass_cnt++;
    end
    bus.raw_buttons = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_glitch_release();
    bus.raw_buttons = 4'b1000;
    for (int k = 0; k < 8; k++) tick();
    total_cnt++;
    if (bus.pushbuttons !== 4'b1000)
      $display("FAIL glitch_accept: pb=%b required 1000", bus.pushbuttons);
    else pass_cnt++;
    bus.raw_buttons = 4'b0000;
    tick();
    tick();
    bus.raw_buttons = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      tick();
      total_cnt++;
      if (bus.pushbuttons !== 4'b1000 || bus.press_evt !== 4'b0000)
        $display("FAIL glitch_hold_%0d: pb=%b evt=%b required 1000/0000",
                 k, bus.pushbuttons, bus.press_evt);
      else pass_cnt++;
    end
    bus.raw_buttons = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    total_cnt++;
    if (bus.pushbuttons !== 4'b0000)
      $display("FAIL glitch_release: pb=%b required 0000", bus.pushbuttons);
    else pass_cnt++;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_flags();
    logic [3:0] exp_b1;
    logic [3:0] exp_b0;
`ifdef PRESS_LATCH_EN
    exp_b1 = 4'b0010;
    exp_b0 = 4'b0001;
`else
    exp_b1 = 4'b0000;
    exp_b0 = 4'b0000;
`endif
    bus.raw_buttons = 4'b0010;
    for (int k = 0; k < 8; k++) tick();
    total_cnt++;
    if (bus.press_flags !== exp_b1)
      $display("FAIL flag_set_b1: flags=%b required %b", bus.press_flags, exp_b1);
    else pass_cnt++;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    total_cnt++;
    if (bus.press_flags !== 4'b0000)
      $display("FAIL flag_ack_b1: flags=%b required 0000", bus.press_flags);
    else pass_cnt++;
    bus.raw_buttons = 4'b0011;
    for (int k = 0; k <= 5; k++) tick();
    total_cnt++;
    if (bus.press_evt !== 4'b0001)
      $display("FAIL flag_evt_b0: evt=%b required 0001", bus.press_evt);
    else pass_cnt++;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    total_cnt++;
    if (bus.press_flags !== exp_b0)
      $display("FAIL flag_set_wins: flags=%b required %b", bus.press_flags, exp_b0);
    else pass_cnt++;
    bus.raw_buttons = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_pb;
    logic [3:0] exp_evt;
    logic [3:0] exp_fl;
    bus.raw_buttons = 4'b1111;
    for (int k = 0; k <= 3; k++) tick();
    total_cnt++;
    if (bus.state_dbg !== 8'h55)
      $display("FAIL mid_arming: st=%h required 55", bus.state_dbg);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.state_dbg !== 8'h00 || bus.pushbuttons !== 4'b0000 ||
        bus.press_evt !== 4'b0000 || bus.press_flags !== 4'b0000)
      $display("FAIL async_reset: st=%h pb=%b evt=%b flags=%b required all 0",
               bus.state_dbg, bus.pushbuttons, bus.press_evt, bus.press_flags);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_pb  = (k >= 6) ? 4'b1111 : 4'b0000;
      exp_evt = (k == 6) ? 4'b1111 : 4'b0000;
      total_cnt++;
      if (bus.pushbuttons !== exp_pb || bus.press_evt !== exp_evt)
        $display("FAIL post_reset_Er+%0d: pb=%b evt=%b required pb=%b evt=%b",
                 k, bus.pushbuttons, bus.press_evt, exp_pb, exp_evt);
      else pass_cnt++;
    end
`ifdef PRESS_LATCH_EN
    exp_fl = 4'b1111;
`else
    exp_fl = 4'b0000;
`endif
    total_cnt++;
    if (bus.press_flags !== exp_fl)
      $display("FAIL post_reset_flags: flags=%b required %b", bus.press_flags, exp_fl);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.raw_buttons = 4'b0000;
    bus.rd_ack = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_release();
    test_flags();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
